// File: rtl/dual_issue_queue.sv
// dual_issue_queue
//
// Two-wide in-order issue queue between the I-Cache fetch stage and the
// register-read/dispatch stage. Fetched instruction pairs are buffered in a
// circular queue. Each cycle the two oldest entries are checked for hazards
// and either both issue or only the oldest does.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   flush             discard every queued instruction (branch redirect)
//   fetch_valid[1:0]  bit0 = fetch_instr0 valid, bit1 = fetch_instr1 valid
//   fetch_instr0/1    older / younger fetched instruction
//   fetch_ready       queue has room for two more entries
//   issue_valid[1:0]  bit0 = issue_instr0 valid, bit1 = issue_instr1 valid
//   issue_instr0/1    oldest / second-oldest entry, zero while not valid
//   issue_ready       backend accepts the issued group this cycle
//   pair_split        two entries present but a hazard limits issue to one
//   occupancy         current entry count
//
// Optional build macro DUAL_ISSUE_STATS_EN adds the 32-bit counters
// stat_dual, stat_single and stat_split.

module dual_issue_queue #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 8,
    parameter int RF_IDX_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [1:0]              fetch_valid,
    input  logic [XLEN-1:0]         fetch_instr0,
    input  logic [XLEN-1:0]         fetch_instr1,
    output logic                    fetch_ready,
    output logic [1:0]              issue_valid,
    output logic [XLEN-1:0]         issue_instr0,
    output logic [XLEN-1:0]         issue_instr1,
    input  logic                    issue_ready,
    output logic                    pair_split,
    output logic [$clog2(DEPTH):0]  occupancy
`ifdef DUAL_ISSUE_STATS_EN
    ,
    output logic [31:0]             stat_dual,
    output logic [31:0]             stat_single,
    output logic [31:0]             stat_split
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [XLEN-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic [XLEN-1:0]     head;
    logic [XLEN-1:0]     second;
    logic [6:0]          op0;
    logic [6:0]          op1;
    logic [RF_IDX_W-1:0] rd0;
    logic [RF_IDX_W-1:0] rd1;
    logic [RF_IDX_W-1:0] rs1_1;
    logic [RF_IDX_W-1:0] rs2_1;
    logic                hazard;
    logic                have_one;
    logic                have_two;
    logic                push_en;
    logic [CNT_W-1:0]    push_cnt;
    logic [CNT_W-1:0]    pop_cnt;

    assign head   = mem[rd_ptr];
    assign second = mem[rd_ptr + PTR_W'(1)];

    assign op0   = head[6:0];
    assign op1   = second[6:0];
    assign rd0   = head[7 +: RF_IDX_W];
    assign rd1   = second[7 +: RF_IDX_W];
    assign rs1_1 = second[15 +: RF_IDX_W];
    assign rs2_1 = second[20 +: RF_IDX_W];

    // Pair hazard between head and head+1: RAW and WAW only count when the
    // older instruction really writes a register (x0 is a sink), control
    // transfers in the older slot always split, and two memory ops compete
    // for the single memory port.
    always_comb begin
        hazard = 1'b0;
        if (rd0 != '0 && (rd0 == rs1_1 || rd0 == rs2_1 || rd0 == rd1)) begin
            hazard = 1'b1;
        end
        if (op0 == OP_BRANCH || op0 == OP_JAL || op0 == OP_JALR) begin
            hazard = 1'b1;
        end
        if ((op0 == OP_LOAD || op0 == OP_STORE) &&
            (op1 == OP_LOAD || op1 == OP_STORE)) begin
            hazard = 1'b1;
        end
    end

    assign have_one = (count != '0);
    assign have_two = (count >= CNT_W'(2));

    assign issue_valid[0] = have_one & ~flush;
    assign issue_valid[1] = have_two & ~flush & ~hazard;
    assign issue_instr0   = issue_valid[0] ? head : '0;
    assign issue_instr1   = issue_valid[1] ? second : '0;
    assign pair_split     = have_two & hazard & ~flush;
    assign occupancy      = count;

    // Readiness is judged on the registered count only, so a pop in the same
    // cycle never opens room for a push.
    assign fetch_ready = (count <= CNT_W'(DEPTH - 2));
    assign push_en     = fetch_ready & fetch_valid[0];
    assign push_cnt    = push_en ? (fetch_valid[1] ? CNT_W'(2) : CNT_W'(1)) : '0;
    assign pop_cnt     = issue_ready ? (CNT_W'(issue_valid[0]) + CNT_W'(issue_valid[1])) : '0;

    // Pointer and count bookkeeping; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
            rd_ptr <= rd_ptr + pop_cnt[PTR_W-1:0];
            count  <= count + push_cnt - pop_cnt;
        end
    end

    // Entry storage is not reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_en && !flush) begin
            mem[wr_ptr] <= fetch_instr0;
            if (fetch_valid[1]) begin
                mem[wr_ptr + PTR_W'(1)] <= fetch_instr1;
            end
        end
    end

`ifdef DUAL_ISSUE_STATS_EN
    // Issue-group statistics, free-running and cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_dual   <= '0;
            stat_single <= '0;
            stat_split  <= '0;
        end else if (issue_ready && !flush) begin
            if (issue_valid == 2'b11) begin
                stat_dual <= stat_dual + 32'd1;
            end
            if (issue_valid == 2'b01) begin
                stat_single <= stat_single + 32'd1;
            end
            if (pair_split) begin
                stat_split <= stat_split + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dual_issue_queue.md
Name: dual_issue_queue

Overview:
- Parametrised successor to the two-wide in-order issue stage.
- Buffers fetched instruction pairs in a circular queue, checks hazards between the two oldest entries, and issues one or two instructions per cycle.
- Adds backend stall (issue_ready), pipeline flush, a structural (single memory port) check and WAW detection.
- Sits between the I-Cache fetch stage and the register-read/dispatch stage.

Parameters:
- XLEN, 32, instruction width in bits.
- DEPTH, 8, queue entries; power of two, at least 4.
- RF_IDX_W, 5, register index width (rd=[11:7], rs1=[19:15], rs2=[24:20]).

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- flush  in  1  discard all queued instructions (branch redirect)
- fetch_valid  in  2  bit0 = fetch_instr0 valid, bit1 = fetch_instr1 valid; 2'b10 is illegal
- fetch_instr0  in  XLEN  older fetched instruction
- fetch_instr1  in  XLEN  younger fetched instruction
- fetch_ready  out  1  queue can accept two entries this cycle
- issue_valid  out  2  bit0 = issue_instr0 valid, bit1 = issue_instr1 valid
- issue_instr0  out  XLEN  oldest queue entry
- issue_instr1  out  XLEN  second-oldest entry; 0 when bit1 is low
- issue_ready  in  1  backend accepts the issued group this cycle
- pair_split  out  1  two entries present, but only one issues because of a hazard
- occupancy  out  $clog2(DEPTH)+1  current entry count

Behaviour:
- Storage: circular buffer with wr_ptr, rd_ptr and count; pointers wrap modulo DEPTH.
- fetch_ready = (count <= DEPTH-2). It is combinational from the registered count and ignores any same-cycle pop.
- Push (fetch_ready & fetch_valid[0]): fetch_instr0 goes to wr_ptr. If fetch_valid[1], fetch_instr1 goes to wr_ptr+1. Pushed = popcount(fetch_valid). Push is ignored when fetch_ready=0.
- Issue outputs are combinational from the queue head.
  - issue_valid[0] = (count >= 1) & ~flush.
  - issue_valid[1] = (count >= 2) & ~flush & ~hazard.
- hazard is true when any of the following holds between head (I0) and head+1 (I1):
  - RAW: rd(I0) != 0 and rd(I0) equals rs1(I1) or rs2(I1).
  - WAW: rd(I0) != 0 and rd(I0) == rd(I1).
  - Control: I0 opcode is 1100011, 1101111 or 1100111.
  - Structural: I0 and I1 opcodes are both in {0000011, 0100011}.
- pair_split = (count >= 2) & hazard & ~flush.
- Pop: when issue_ready is high, popped = popcount(issue_valid), and rd_ptr advances by popped.
- Next count = count + pushed − popped. Simultaneous push and pop are legal in every state, including full and empty.
- Latency: an entry pushed at edge N is visible on issue_* after edge N. There is no same-cycle bypass.
- Order: issue is strictly in program order, and fetch_instr0 is older than fetch_instr1.
- Flush: at the edge, count, rd_ptr and wr_ptr all reset to 0. Flush has priority over same-cycle push and pop, so neither takes effect. Outputs are invalid during the flush cycle.
- Reset: count=0, pointers=0, storage need not be cleared. After reset: issue_valid=2'b00, issue_instr0/1=0 (masked while invalid), fetch_ready=1, pair_split=0, occupancy=0.
- issue_instr0 reads 0 when issue_valid[0]=0; issue_instr1 reads 0 when issue_valid[1]=0.
- Reset mid-operation: all in-flight entries are lost and the state matches post-reset.

Optional Feature:
- Macro: DUAL_ISSUE_STATS_EN.
- When defined, add 32-bit outputs stat_dual, stat_single and stat_split. Each cycle with issue_ready & ~flush increments:
  - stat_dual when issue_valid=2'b11,
  - stat_single when issue_valid=2'b01,
  - stat_split additionally when pair_split=1.
- Counters wrap at 2^32 and clear only on rst.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Independent pair: push addi x1,x2,1 and addi x3,x4,2, issue_ready=1 → next cycle issue_valid=2'b11, both instructions issued, occupancy returns to 0.
- RAW: push addi x5,x0,1 then add x6,x5,x7 → cycle 1 issue_valid=01, pair_split=1; cycle 2 issue_valid=01 with add; rd=x0 in I0 never raises a hazard.
- Branch/structural: beq in I0 → single issue. lw followed by sw → single issue, then sw issues alone next cycle.
- Full/stall: issue_ready=0, push four pairs with DEPTH=8 → occupancy=8, fetch_ready=0, and a fifth push is ignored. Raising issue_ready drains the queue in order, two per cycle.
- Flush: with occupancy=5 and simultaneous push and flush → next cycle occupancy=0 and issue_valid=00; the pushed pair is discarded.
- Async reset mid-stream: assert rst between edges → outputs reset immediately, fetch_ready=1. With DUAL_ISSUE_STATS_EN defined, the counters also read 0.
